// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the PC, issues one-outstanding-request fetches
// to instruction memory and hands instructions to decode, squashing stale fetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        drop;
    logic        drop_next;
    logic [31:0] inst_next;
    logic [31:0] inst_pc_next;
    logic        misalign_next;
    logic [31:0] target;

    // Redirect targets are always word-aligned; a misaligned request is reported, not honoured.
    assign target = {redirect_pc[31:2], 2'b00};

    assign imem_req   = (state == REQ);
    assign inst_valid = (state == HOLD);
    assign imem_addr  = pc;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next    = state;
        pc_next       = pc;
        drop_next     = drop;
        inst_next     = inst;
        inst_pc_next  = inst_pc;
        misalign_next = redirect && (redirect_pc[1:0] != 2'b00);

        case (state)
            IDLE: begin
                state_next = REQ;
                if (redirect) begin
                    pc_next = target;
                end
            end

            REQ: begin
                if (redirect) begin
                    pc_next = target;
                    if (imem_gnt) begin
                        // The old-pc request is already in flight; its data must be discarded.
                        drop_next  = 1'b1;
                        state_next = WAIT;
                    end
                end else if (imem_gnt) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (redirect) begin
                    pc_next = target;
                    if (imem_rvalid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        inst_next    = imem_rdata;
                        inst_pc_next = pc;
                        pc_next      = pc + 32'd4;
                        state_next   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    inst_next  = NOP_INST;
                    pc_next    = target;
                    state_next = REQ;
                end else if (id_ready) begin
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            drop         <= 1'b0;
            inst         <= NOP_INST;
            inst_pc      <= 32'h0000_0000;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            drop         <= drop_next;
            inst         <= inst_next;
            inst_pc      <= inst_pc_next;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end and the consumer of the branch comparator's br_taken. Holds the PC, issues one-outstanding-request fetches to instruction memory with a req/gnt and rvalid handshake, and presents instructions to decode with a valid/ready handshake. Redirects the PC when a taken branch or jump is signalled and discards stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INST, 32'h0000_0013, value of inst while reset or flushed (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
redirect  input  1  br_taken OR jump from execute; 1 = load redirect_pc.
redirect_pc  input  32  branch/jump target.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address, always equal to pc.
imem_gnt  input  1  request accepted this cycle when imem_req=1.
imem_rvalid  input  1  read data returned (exactly one per granted request).
imem_rdata  input  32  instruction word.
inst_valid  output  1  inst/inst_pc valid to decode.
inst  output  32  fetched instruction.
inst_pc  output  32  address of inst.
id_ready  input  1  decode accepts inst this cycle when inst_valid=1.
misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=IDLE, drop=0, imem_req=0, inst_valid=0, inst=NOP_INST, inst_pc=0, misalign_err=0.
- States: IDLE, REQ, WAIT, HOLD. imem_req=1 only in REQ; inst_valid=1 only in HOLD (both Moore outputs from state).
- IDLE: unconditionally -> REQ next cycle.
- REQ: imem_gnt=1 -> WAIT. Redirect without gnt: pc<=redirect_pc, stay REQ (new address seen next cycle). Redirect with gnt same cycle: old-pc request is outstanding; drop<=1, pc<=redirect_pc, -> WAIT.
- WAIT: imem_rvalid=1 and drop=0 and no redirect: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, -> HOLD. imem_rvalid=1 and drop=1: discard, drop<=0, -> REQ. Redirect without rvalid: drop<=1, pc<=redirect_pc, stay WAIT. Redirect with rvalid same cycle: discard data, drop<=0, pc<=redirect_pc, -> REQ.
- HOLD: inst/inst_pc held stable until accepted. id_ready=1 and no redirect -> REQ. Redirect (regardless of id_ready): flush, inst<=NOP_INST, pc<=redirect_pc, -> REQ.
- Redirect has priority over every other event in every state; in IDLE it only updates pc.
- redirect_pc[1:0] forced to 2'b00 when loaded; misalign_err=1 the cycle after any redirect with nonzero low bits, else 0.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
- Never more than one outstanding request; imem_req low from gnt until the matching rvalid.
- Reset mid-operation: all state returns to reset values next edge; any in-flight rvalid after reset arrives in IDLE/REQ and is ignored.
- Minimum latency: req in cycle N, gnt in N, rvalid in N+1 -> inst_valid in N+2; sustained throughput one instruction per 3 cycles.

Test Plan:
- Reset then zero-wait memory (gnt=1, rvalid one cycle later, rdata=addr^32'hA5A5_0000), id_ready=1 -> inst_pc sequence 0,4,8,12, each inst matches, imem_addr 0,4,8.
- id_ready=0 for 5 cycles in HOLD at inst_pc=8 -> inst/inst_pc stable, imem_req=0, then accept -> next fetch at 12.
- Redirect to 32'h0000_0100 while in WAIT for addr 4 -> stale rvalid discarded, next imem_addr=0x100, next inst_pc=0x100, addr-4 data never appears.
- Redirect to 0x200 coincident with gnt for addr 8 -> one discarded rvalid, then fetch at 0x200; redirect coincident with rvalid -> data dropped, fetch at target next.
- Redirect to 32'h0000_0303 -> misalign_err pulses once, imem_addr=32'h0000_0300.
- rst_n=0 for one cycle while in WAIT, rvalid arrives after release -> ignored, first inst_pc=RESET_PC; pc at 32'hFFFF_FFFC increments to 0.
